// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline control slice.
//   ctrl_state_e : memory-wait controller states (RUN, MEM_WAIT, FAULT)
//   REG_IDX_W    : register-index width used by hazard comparisons
//   STALL_CNT_W  : width of the saturating frozen-cycle counter
//   WAIT_CNT_W   : width of the memory-wait cycle counter
package arm_pipe_pkg;

  localparam int unsigned REG_IDX_W   = 4;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned WAIT_CNT_W  = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational source/destination match for the ID stage.
// Build option: FORWARDING_EN -- when defined only load-use hazards are
// reported (results can otherwise be forwarded); when undefined any valid
// source matching an in-flight EXE or MEM destination is a hazard.
// Ports:
//   src1_i, src2_i       ID source register indices
//   src1Valid_i, twoSrc_i ID instruction reads src1 / src2
//   exeDest_i, exeWbEn_i, exeMemRead_i  EXE destination, write-enable, load
//   memDest_i, memWbEn_i MEM destination and write-enable
//   hazard_o             ID instruction must wait
module hazard_detect
  import arm_pipe_pkg::*;
(
  input  reg_idx_t src1_i,
  input  reg_idx_t src2_i,
  input  logic     src1Valid_i,
  input  logic     twoSrc_i,
  input  reg_idx_t exeDest_i,
  input  logic     exeWbEn_i,
  input  logic     exeMemRead_i,
  input  reg_idx_t memDest_i,
  input  logic     memWbEn_i,
  output logic     hazard_o
);

  logic exe_match;
  logic mem_match;

  assign exe_match = (src1Valid_i && (src1_i == exeDest_i)) ||
                     (twoSrc_i    && (src2_i == exeDest_i));
  assign mem_match = (src1Valid_i && (src1_i == memDest_i)) ||
                     (twoSrc_i    && (src2_i == memDest_i));

`ifdef FORWARDING_EN
  logic unused_mem_match;
  logic unused_mem_wb;
  assign unused_mem_match = mem_match;
  assign unused_mem_wb    = memWbEn_i;
  assign hazard_o = exeMemRead_i && exeWbEn_i && exe_match;
`else
  logic unused_exe_mem_read;
  assign unused_exe_mem_read = exeMemRead_i;
  assign hazard_o = (exeWbEn_i && exe_match) || (memWbEn_i && mem_match);
`endif

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller with data-memory wait timeout.
// Build option: FORWARDING_EN (selects load-use-only hazard detection).
// Parameter TIMEOUT_CYCLES (1..255): memory-wait cycles tolerated in
// MEM_WAIT before the controller latches a fault.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   branchTaken           branch resolved taken in EXE
//   src1, src2, src1Valid, twoSrc            ID sources
//   exeDest, exeWbEn, exeMemRead             EXE destination info
//   memDest, memWbEn                         MEM destination info
//   memAccess, memReady                      data-memory handshake
//   freeze, bubble, flush, stallAll          pipeline controls
//   memTimeout            sticky fault flag
//   stallCount            saturating count of frozen cycles
module pipeline_controller
  import arm_pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branchTaken,
  input  logic [REG_IDX_W-1:0]   src1,
  input  logic [REG_IDX_W-1:0]   src2,
  input  logic                   src1Valid,
  input  logic                   twoSrc,
  input  logic [REG_IDX_W-1:0]   exeDest,
  input  logic                   exeWbEn,
  input  logic                   exeMemRead,
  input  logic [REG_IDX_W-1:0]   memDest,
  input  logic                   memWbEn,
  input  logic                   memAccess,
  input  logic                   memReady,
  output logic                   freeze,
  output logic                   bubble,
  output logic                   flush,
  output logic                   stallAll,
  output logic                   memTimeout,
  output logic [STALL_CNT_W-1:0] stallCount
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic [STALL_CNT_W-1:0] stallCount_q, stallCount_d;
  logic                   memTimeout_q, memTimeout_d;

  logic hazard;
  logic mem_stall;
  logic stall_raw;

  hazard_detect u_hazard_detect (
    .src1_i       (src1),
    .src2_i       (src2),
    .src1Valid_i  (src1Valid),
    .twoSrc_i     (twoSrc),
    .exeDest_i    (exeDest),
    .exeWbEn_i    (exeWbEn),
    .exeMemRead_i (exeMemRead),
    .memDest_i    (memDest),
    .memWbEn_i    (memWbEn),
    .hazard_o     (hazard)
  );

  assign mem_stall = memAccess && !memReady;

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      RUN: begin
        waitCnt_d = '0;
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (memReady || !memAccess) begin
          state_d   = RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d = FAULT;
        end else begin
          waitCnt_d = waitCnt_q + WAIT_CNT_W'(1);
        end
      end
      FAULT: state_d = FAULT;
      default: begin
        state_d   = RUN;
        waitCnt_d = '0;
      end
    endcase
  end

  // Controls are forced low while reset is held, independent of inputs.
  always_comb begin
    stall_raw = (state_q == FAULT) || mem_stall;
    stallAll  = !rst && stall_raw;
    flush     = !rst && branchTaken && !stall_raw;
    freeze    = !rst && (stall_raw || (hazard && !branchTaken));
    bubble    = !rst && hazard && !branchTaken && !stall_raw;
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (freeze && (stallCount_q != '1)) stallCount_d = stallCount_q + STALL_CNT_W'(1);
    memTimeout_d = memTimeout_q || (state_d == FAULT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      waitCnt_q    <= '0;
      stallCount_q <= '0;
      memTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      stallCount_q <= stallCount_d;
      memTimeout_q <= memTimeout_d;
    end
  end

  assign stallCount = stallCount_q;
  assign memTimeout = memTimeout_q;

endmodule
